// File: rtl/linebuffer_2x2_seq_ctrl_pkg.sv
// Shared types and defaults for the 2x2 line-buffer frame sequencer.
// The optional window counter is enabled by defining LB2X2_WIN_CNT_EN.
package linebuffer_2x2_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   localparam logic [2:0] SEL_MAX = 3'd5;

   localparam int unsigned CW_DEFAULT = 8;

   localparam int unsigned LEN1_DEF = 16;
   localparam int unsigned LEN2_DEF = 14;
   localparam int unsigned LEN3_DEF = 28;
   localparam int unsigned LEN4_DEF = 56;
   localparam int unsigned LEN5_DEF = 112;
   localparam int unsigned LEN6_DEF = 224;

   function automatic logic sel_legal(input logic [2:0] s);
      return s <= SEL_MAX;
   endfunction

endpackage

// File: rtl/lb_valid_delay.sv
// Depth-stage shift register aligning window strobes/indices with line-buffer latency.
// Depth=0 degenerates to a wire.
module lb_valid_delay #(
   parameter int unsigned Depth = 1,
   parameter int unsigned Width = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o
);

   if (Depth == 0) begin : g_wire
      assign data_o = data_i;
   end else begin : g_pipe
      logic [Width-1:0] pipe_q [Depth];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) pipe_q[i] <= '0;
         end else begin
            pipe_q[0] <= data_i;
            for (int unsigned i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign data_o = pipe_q[Depth-1];
   end

endmodule

// File: rtl/linebuffer_2x2_seq_ctrl.sv
// Frame sequencer for the 8-lane 2x2 line-buffer bank: config handshake, raster counting,
// latency-aligned window strobes. Define LB2X2_WIN_CNT_EN to add the win_cnt output.
module linebuffer_2x2_seq_ctrl
   import linebuffer_2x2_seq_ctrl_pkg::*;
#(
   parameter int unsigned LEN1   = LEN1_DEF,
   parameter int unsigned LEN2   = LEN2_DEF,
   parameter int unsigned LEN3   = LEN3_DEF,
   parameter int unsigned LEN4   = LEN4_DEF,
   parameter int unsigned LEN5   = LEN5_DEF,
   parameter int unsigned LEN6   = LEN6_DEF,
   parameter int unsigned CW     = CW_DEFAULT,
   parameter int unsigned LB_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_start,
   input  logic [2:0]    cfg_sel,
   input  logic          cfg_stride2,
   output logic          cfg_ready,
   output logic          cfg_err,
   output logic [2:0]    sel,
   input  logic          pix_valid,
   output logic          pix_ready,
   output logic          win_valid,
   output logic [CW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          frame_done,
   output logic          stall_err
`ifdef LB2X2_WIN_CNT_EN
   ,output logic [2*CW-1:0] win_cnt
`endif
);

   localparam int unsigned PipeW = 2 * CW + 2;

   state_e        state_q, state_d;
   logic [2:0]    sel_q, sel_d;
   logic          stride2_q, stride2_d;
   logic [CW-1:0] w_q, w_d;
   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          cfg_ready_q, cfg_ready_d;
   logic          pix_ready_q, pix_ready_d;
   logic          cfg_err_q, cfg_err_d;
   logic          stall_err_q, stall_err_d;

   logic [CW-1:0]    w_sel;
   logic             accept, beat, col_last, row_last, last_pix, win_hit;
   logic [CW-1:0]    win_r, win_c;
   logic [PipeW-1:0] pipe_in, pipe_out;

   always_comb begin
      case (cfg_sel)
         3'd0:    w_sel = CW'(LEN1);
         3'd1:    w_sel = CW'(LEN2);
         3'd2:    w_sel = CW'(LEN3);
         3'd3:    w_sel = CW'(LEN4);
         3'd4:    w_sel = CW'(LEN5);
         3'd5:    w_sel = CW'(LEN6);
         default: w_sel = CW'(LEN1);
      endcase
   end

   assign accept   = (state_q == StIdle) && cfg_start && sel_legal(cfg_sel);
   assign beat     = (state_q == StRun) && pix_valid;
   assign col_last = (col_q == w_q - CW'(1));
   assign row_last = (row_q == w_q - CW'(1));
   assign last_pix = beat && col_last && row_last;

   // A window closes on the bottom-right pixel of each 2x2 block.
   assign win_hit = beat && (row_q != '0) && (col_q != '0) &&
                    (!stride2_q || (row_q[0] && col_q[0]));

   always_comb begin
      win_r = '0;
      win_c = '0;
      if (win_hit) begin
         win_r = stride2_q ? (row_q >> 1) : (row_q - CW'(1));
         win_c = stride2_q ? (col_q >> 1) : (col_q - CW'(1));
      end
   end

   assign pipe_in = {last_pix, win_hit, win_r, win_c};

   lb_valid_delay #(
      .Depth(LB_LAT),
      .Width(PipeW)
   ) u_valid_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .data_i(pipe_in),
      .data_o(pipe_out)
   );

   assign frame_done = pipe_out[PipeW-1];
   assign win_valid  = pipe_out[PipeW-2];
   assign win_row    = pipe_out[2*CW-1:CW];
   assign win_col    = pipe_out[CW-1:0];

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      stride2_d   = stride2_q;
      w_d         = w_q;
      row_d       = row_q;
      col_d       = col_q;
      cfg_err_d   = 1'b0;
      stall_err_d = stall_err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               sel_d       = cfg_sel;
               stride2_d   = cfg_stride2;
               w_d         = w_sel;
               row_d       = '0;
               col_d       = '0;
               stall_err_d = 1'b0;
               state_d     = StRun;
            end else if (cfg_start) begin
               cfg_err_d = 1'b1;
            end
         end
         StRun: begin
            if (pix_valid) begin
               if (col_last) begin
                  col_d = '0;
                  row_d = row_q + CW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (last_pix) begin
                  row_d   = '0;
                  state_d = (LB_LAT == 0) ? StIdle : StDrain;
               end
            end else if ((row_q != '0) || (col_q != '0)) begin
               // Line buffers shift regardless, so any gap after the first beat corrupts windows.
               stall_err_d = 1'b1;
            end
         end
         StDrain: begin
            if (frame_done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      cfg_ready_d = (state_d == StIdle);
      pix_ready_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         stride2_q   <= 1'b0;
         w_q         <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cfg_ready_q <= 1'b1;
         pix_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         stride2_q   <= stride2_d;
         w_q         <= w_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cfg_ready_q <= cfg_ready_d;
         pix_ready_q <= pix_ready_d;
         cfg_err_q   <= cfg_err_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign pix_ready = pix_ready_q;
   assign cfg_err   = cfg_err_q;
   assign stall_err = stall_err_q;
   assign sel       = sel_q;

`ifdef LB2X2_WIN_CNT_EN
   logic [2*CW-1:0] win_cnt_q, win_cnt_d;

   always_comb begin
      win_cnt_d = win_cnt_q;
      if (accept)         win_cnt_d = '0;
      else if (win_valid) win_cnt_d = win_cnt_q + (2*CW)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) win_cnt_q <= '0;
      else        win_cnt_q <= win_cnt_d;
   end

   assign win_cnt = win_cnt_q;
`endif

endmodule

// File: tb/tb_linebuffer_2x2_seq_ctrl.sv
// Scoreboard bench for linebuffer_2x2_seq_ctrl; covers win_cnt when LB2X2_WIN_CNT_EN is defined.
module tb_linebuffer_2x2_seq_ctrl;

   localparam int LB_LAT = 1;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] c;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_start, cfg_stride2, pix_valid;
   logic [2:0] cfg_sel;
   logic       cfg_ready, cfg_err, pix_ready, win_valid, frame_done, stall_err;
   logic [2:0] sel;
   logic [7:0] win_row, win_col;
`ifdef LB2X2_WIN_CNT_EN
   logic [15:0] win_cnt;
`endif

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   win_seen = 0;
   int   first_win_cyc = 0;
   int   last_r = 0;
   int   last_c = 0;
   logic done_flag = 1'b0;
   exp_t exp_q[$];

   linebuffer_2x2_seq_ctrl #(.LB_LAT(LB_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_sel    (cfg_sel),
      .cfg_stride2(cfg_stride2),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .sel        (sel),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done),
      .stall_err  (stall_err)
`ifdef LB2X2_WIN_CNT_EN
      ,.win_cnt   (win_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expected window per observed win_valid.
   always @(negedge clk) begin
      if (rst_n) begin
         if (win_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL win_unexpected: got window (%0d,%0d) required none", win_row, win_col);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("win_row", 32'(win_row), 32'(e.r));
               check("win_col", 32'(win_col), 32'(e.c));
               check("frame_done_align", 32'(frame_done), 32'(e.done));
            end
            if (win_seen == 0) first_win_cyc = cyc;
            win_seen++;
            last_r = int'(win_row);
            last_c = int'(win_col);
            if (frame_done) done_flag = 1'b1;
         end else begin
            check("frame_done_without_window", 32'(frame_done), 32'd0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
      check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
      check({tag, "_sel"}, 32'(sel), 32'd0);
      check({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
      check({tag, "_win_valid"}, 32'(win_valid), 32'd0);
      check({tag, "_win_row"}, 32'(win_row), 32'd0);
      check({tag, "_win_col"}, 32'(win_col), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_stall_err"}, 32'(stall_err), 32'd0);
`ifdef LB2X2_WIN_CNT_EN
      check({tag, "_win_cnt"}, 32'(win_cnt), 32'd0);
`endif
   endtask

   // Called at posedge+1 with the block idle; returns at posedge+1 after acceptance.
   task automatic do_start(input logic [2:0] s, input logic s2);
      win_seen  = 0;
      done_flag = 1'b0;
      cfg_sel     = s;
      cfg_stride2 = s2;
      cfg_start   = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
   endtask

   task automatic feed(input int w, input logic s2, input int nbeats, input int gap_at,
                       output int k0);
      int r, c;
      k0 = 0;
      for (int i = 0; i < nbeats; i++) begin
         if (i == gap_at) begin
            pix_valid = 1'b0;
            repeat (3) begin
               @(posedge clk);
               #1;
            end
            check("stall_err_after_gap", 32'(stall_err), 32'd1);
            check("pix_ready_in_gap", 32'(pix_ready), 32'd1);
         end
         r = i / w;
         c = i % w;
         if (r >= 1 && c >= 1 && (!s2 || ((r % 2) == 1 && (c % 2) == 1)))
            exp_q.push_back('{r: 8'(s2 ? r / 2 : r - 1), c: 8'(s2 ? c / 2 : c - 1),
                              done: (i == w * w - 1)});
         if (i == 0) k0 = cyc;
         pix_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_flag && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("frame_done_seen", 32'(done_flag), 32'd1);
   endtask

   initial begin
      int k0;
      rst_n       = 1'b0;
      cfg_start   = 1'b0;
      cfg_sel     = 3'd0;
      cfg_stride2 = 1'b0;
      pix_valid   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("after_reset");

      // Illegal select: error pulse, stays idle, sel untouched.
      cfg_sel   = 3'd6;
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      check("cfg_err_pulse", 32'(cfg_err), 32'd1);
      check("cfg_ready_after_bad", 32'(cfg_ready), 32'd1);
      check("sel_after_bad", 32'(sel), 32'd0);
      check("pix_ready_after_bad", 32'(pix_ready), 32'd0);
      @(posedge clk);
      #1;
      check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);

      // sel=1 (W=14), stride 2.
      do_start(3'd1, 1'b1);
      check("a_sel", 32'(sel), 32'd1);
      check("a_cfg_ready", 32'(cfg_ready), 32'd0);
      check("a_pix_ready", 32'(pix_ready), 32'd1);
      feed(14, 1'b1, 196, -1, k0);
      wait_done(20);
      check("a_windows", 32'(win_seen), 32'd49);
      check("a_first_win_beat", 32'(first_win_cyc - k0), 32'(15 + LB_LAT));
      check("a_last_row", 32'(last_r), 32'd6);
      check("a_last_col", 32'(last_c), 32'd6);
      check("a_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef LB2X2_WIN_CNT_EN
      check("a_win_cnt", 32'(win_cnt), 32'd49);
`endif
      check("a_ready_after_done", 32'(cfg_ready), 32'd1);
      check("a_sel_held", 32'(sel), 32'd1);

      // Back-to-back: sel=5 (W=224), stride 2, started the cycle after frame_done.
      do_start(3'd5, 1'b1);
      check("b_sel", 32'(sel), 32'd5);
      check("b_pix_ready", 32'(pix_ready), 32'd1);
      feed(224, 1'b1, 50176, -1, k0);
      wait_done(20);
      check("b_windows", 32'(win_seen), 32'd12544);
      check("b_last_row", 32'(last_r), 32'd111);
      check("b_last_col", 32'(last_c), 32'd111);
      check("b_queue_empty", 32'(exp_q.size()), 32'd0);

      // sel=2 (W=28), stride 2, 3-cycle gap mid-row.
      do_start(3'd2, 1'b1);
      check("c_stall_clear_at_start", 32'(stall_err), 32'd0);
      feed(28, 1'b1, 784, 40, k0);
      wait_done(20);
      check("c_windows", 32'(win_seen), 32'd196);
      check("c_last_row", 32'(last_r), 32'd13);
      check("c_last_col", 32'(last_c), 32'd13);
      check("c_stall_sticky", 32'(stall_err), 32'd1);
      check("c_queue_empty", 32'(exp_q.size()), 32'd0);

      // sel=3 (W=56), reset mid-frame at beat 100.
      do_start(3'd3, 1'b0);
      check("d_stall_cleared", 32'(stall_err), 32'd0);
      check("d_sel", 32'(sel), 32'd3);
      feed(56, 1'b0, 100, -1, k0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_frame_reset");
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("d_no_frame_done", 32'(done_flag), 32'd0);
      check("d_ready_idle", 32'(cfg_ready), 32'd1);

      // sel=0 (W=16), stride 1.
      do_start(3'd0, 1'b0);
      check("e_pix_ready", 32'(pix_ready), 32'd1);
      feed(16, 1'b0, 256, -1, k0);
      wait_done(20);
      check("e_windows", 32'(win_seen), 32'd225);
      check("e_first_win_beat", 32'(first_win_cyc - k0), 32'(17 + LB_LAT));
      check("e_last_row", 32'(last_r), 32'd14);
      check("e_last_col", 32'(last_c), 32'd14);
      check("e_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef LB2X2_WIN_CNT_EN
      check("e_win_cnt", 32'(win_cnt), 32'd225);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("e_idle_after", 32'(cfg_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
